// File: rtl/xbox_xlr_vadd.sv
// xbox_xlr_vadd: lane-wise vector add/sub accelerator over XBOX line memories.
// Each line reads A, then B, then writes MODE(A, B) over 8 x 32-bit lanes.
module xbox_xlr_vadd #(
  parameter int NUM_MEMS           = 1,
  parameter int LOG2_LINES_PER_MEM = 4
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]  xlr_mem_addr_o,
  output logic [NUM_MEMS-1:0][7:0][31:0]               xlr_mem_wdata_o,
  output logic [NUM_MEMS-1:0][31:0]                    xlr_mem_be_o,
  output logic [NUM_MEMS-1:0]                          xlr_mem_rd_o,
  output logic [NUM_MEMS-1:0]                          xlr_mem_wr_o,
  input  logic [NUM_MEMS-1:0][7:0][31:0]               xlr_mem_rdata_i,
  input  logic [31:0][31:0]                            host_regs_i,
  input  logic [31:0]                                  host_regs_valid_pulse_i,
  output logic [31:0][31:0]                            host_regs_data_out_o,
  output logic [31:0]                                  host_regs_valid_out_o,
  input  logic [18:0]                                  trig_soc_xmem_wr_addr_i,
  input  logic                                         trig_soc_xmem_wr_i
);

  localparam int         LW         = LOG2_LINES_PER_MEM;
  localparam logic [7:0] NUM_MEMS_B = 8'(NUM_MEMS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic            armed_q, armed_d;
  logic [7:0]      a_inst_q, a_inst_d;
  logic [7:0]      b_inst_q, b_inst_d;
  logic [7:0]      dst_inst_q, dst_inst_d;
  logic [LW-1:0]   a_ptr_q, a_ptr_d;
  logic [LW-1:0]   b_ptr_q, b_ptr_d;
  logic [LW-1:0]   dst_ptr_q, dst_ptr_d;
  logic [8:0]      count_q, count_d;
  logic [8:0]      lines_q, lines_d;
  logic [1:0]      mode_q, mode_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            aborted_q, aborted_d;
  logic [7:0][31:0] a_q, a_d;
  logic [7:0][31:0] b_q, b_d;

  logic             is_idle;
  logic             ctrl_wr;
  logic             trig_hit;
  logic             start;
  logic             abort;
  logic             idx_bad;
  logic             cnt_zero;
  logic             last_line;
  logic [7:0][31:0] rdata_a;
  logic [7:0][31:0] rdata_b;
  logic [7:0][31:0] result;
  logic [31:0]      status;

  function automatic logic [31:0] lane_op(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [1:0]  mode);
    logic [32:0] sum;
    logic [32:0] diff;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    case (mode)
      2'd0:    lane_op = sum[31:0];
      2'd1:    lane_op = diff[31:0];
      2'd2:    lane_op = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
      default: lane_op = diff[32] ? 32'h0 : diff[31:0];
    endcase
  endfunction

  // Control decode; the trigger only counts as a start while idle and armed.
  assign ctrl_wr   = host_regs_valid_pulse_i[0];
  assign is_idle   = (state_q == S_IDLE);
  assign trig_hit  = armed_q & trig_soc_xmem_wr_i &
                     (trig_soc_xmem_wr_addr_i == host_regs_i[7][18:0]);
  assign start     = is_idle & ((ctrl_wr & host_regs_i[0][0]) | trig_hit);
  assign abort     = ~is_idle & ctrl_wr & host_regs_i[0][2];
  assign idx_bad   = (host_regs_i[1][15:8] >= NUM_MEMS_B) |
                     (host_regs_i[2][15:8] >= NUM_MEMS_B) |
                     (host_regs_i[3][15:8] >= NUM_MEMS_B);
  assign cnt_zero  = (host_regs_i[4][8:0] == 9'd0);
  assign last_line = ((lines_q + 9'd1) >= count_q);

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int m = 0; m < NUM_MEMS; m++) begin
      if (a_inst_q == 8'(m)) rdata_a = xlr_mem_rdata_i[m];
      if (b_inst_q == 8'(m)) rdata_b = xlr_mem_rdata_i[m];
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign result[gi] = lane_op(a_q[gi], b_q[gi], mode_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && !idx_bad && !cnt_zero) state_d = S_RDA;
      S_RDA:   state_d = S_RDB;
      S_RDB:   state_d = S_CAP;
      S_CAP:   state_d = S_WR;
      S_WR:    state_d = last_line ? S_IDLE : S_RDA;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    armed_d    = armed_q;
    a_inst_d   = a_inst_q;
    b_inst_d   = b_inst_q;
    dst_inst_d = dst_inst_q;
    a_ptr_d    = a_ptr_q;
    b_ptr_d    = b_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    count_d    = count_q;
    lines_d    = lines_q;
    mode_d     = mode_q;
    done_d     = done_q;
    err_d      = err_q;
    aborted_d  = aborted_q;
    a_d        = a_q;
    b_d        = b_q;

    // A trigger-initiated start disarms even if START arrives in the same cycle.
    if (is_idle && trig_hit) begin
      armed_d = 1'b0;
    end else if (ctrl_wr) begin
      armed_d = host_regs_i[0][1];
    end

    if (start) begin
      a_inst_d   = host_regs_i[1][15:8];
      b_inst_d   = host_regs_i[2][15:8];
      dst_inst_d = host_regs_i[3][15:8];
      a_ptr_d    = host_regs_i[1][LW-1:0];
      b_ptr_d    = host_regs_i[2][LW-1:0];
      dst_ptr_d  = host_regs_i[3][LW-1:0];
      count_d    = host_regs_i[4][8:0];
      mode_d     = host_regs_i[6][1:0];
      lines_d    = 9'd0;
      done_d     = idx_bad | cnt_zero;
      err_d      = idx_bad;
      aborted_d  = 1'b0;
    end

    unique case (state_q)
      S_RDB: a_d = rdata_a;
      S_CAP: b_d = rdata_b;
      S_WR: begin
        lines_d   = lines_q + 9'd1;
        a_ptr_d   = a_ptr_q + 1'b1;
        b_ptr_d   = b_ptr_q + 1'b1;
        dst_ptr_d = dst_ptr_q + 1'b1;
        if (last_line) done_d = 1'b1;
      end
      default: ;
    endcase

    if (abort) begin
      aborted_d = 1'b1;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      armed_q    <= 1'b0;
      a_inst_q   <= '0;
      b_inst_q   <= '0;
      dst_inst_q <= '0;
      a_ptr_q    <= '0;
      b_ptr_q    <= '0;
      dst_ptr_q  <= '0;
      count_q    <= '0;
      lines_q    <= '0;
      mode_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      aborted_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      armed_q    <= armed_d;
      a_inst_q   <= a_inst_d;
      b_inst_q   <= b_inst_d;
      dst_inst_q <= dst_inst_d;
      a_ptr_q    <= a_ptr_d;
      b_ptr_q    <= b_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      count_q    <= count_d;
      lines_q    <= lines_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
      err_q      <= err_d;
      aborted_q  <= aborted_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  // Memory strobes decode from registered state only.
  always_comb begin
    xlr_mem_addr_o  = '0;
    xlr_mem_wdata_o = '0;
    xlr_mem_be_o    = '0;
    xlr_mem_rd_o    = '0;
    xlr_mem_wr_o    = '0;
    for (int m = 0; m < NUM_MEMS; m++) begin
      if (state_q == S_RDA && a_inst_q == 8'(m)) begin
        xlr_mem_rd_o[m]   = 1'b1;
        xlr_mem_addr_o[m] = a_ptr_q;
      end
      if (state_q == S_RDB && b_inst_q == 8'(m)) begin
        xlr_mem_rd_o[m]   = 1'b1;
        xlr_mem_addr_o[m] = b_ptr_q;
      end
      if (state_q == S_WR && dst_inst_q == 8'(m)) begin
        xlr_mem_wr_o[m]    = 1'b1;
        xlr_mem_addr_o[m]  = dst_ptr_q;
        xlr_mem_be_o[m]    = '1;
        xlr_mem_wdata_o[m] = result;
      end
    end
  end

  assign status = {7'd0, lines_q, 12'd0, aborted_q, err_q, done_q, ~is_idle};

  always_comb begin
    host_regs_data_out_o    = '0;
    host_regs_data_out_o[5] = status;
  end

  assign host_regs_valid_out_o = 32'h0000_0020;

endmodule

// File: tb/tb_xbox_xlr_vadd.sv
// Scoreboarded bench for xbox_xlr_vadd with two memory instances of 16 lines.
// Stimulus queues expected writes; a negedge monitor pops and checks them.
module tb_xbox_xlr_vadd;

  localparam int NM = 2;
  localparam int LW = 4;

  logic                          clk;
  logic                          rst;
  logic [NM-1:0][LW-1:0]         addr;
  logic [NM-1:0][7:0][31:0]      wdata;
  logic [NM-1:0][31:0]           be;
  logic [NM-1:0]                 rd;
  logic [NM-1:0]                 wr;
  logic [NM-1:0][7:0][31:0]      rdata;
  logic [31:0][31:0]             hregs;
  logic [31:0]                   hpulse;
  logic [31:0][31:0]             hdata;
  logic [31:0]                   hvalid;
  logic [18:0]                   taddr;
  logic                          twr;
  logic [31:0]                   status;

  typedef struct {
    int           mem;
    int           line;
    logic [255:0] data;
  } exp_t;

  exp_t         exp_q[$];
  logic [255:0] mem [NM][16];
  int           checks;
  int           errors;
  int           strobes;

  xbox_xlr_vadd #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(LW)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .xlr_mem_addr_o          (addr),
    .xlr_mem_wdata_o         (wdata),
    .xlr_mem_be_o            (be),
    .xlr_mem_rd_o            (rd),
    .xlr_mem_wr_o            (wr),
    .xlr_mem_rdata_i         (rdata),
    .host_regs_i             (hregs),
    .host_regs_valid_pulse_i (hpulse),
    .host_regs_data_out_o    (hdata),
    .host_regs_valid_out_o   (hvalid),
    .trig_soc_xmem_wr_addr_i (taddr),
    .trig_soc_xmem_wr_i      (twr)
  );

  assign status = hdata[5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data is returned the cycle after rd.
  always @(posedge clk) begin
    for (int m = 0; m < NM; m++) begin
      if (wr[m]) mem[m][addr[m]] = wdata[m];
      if (rd[m]) rdata[m] <= mem[m][addr[m]];
    end
  end

  function automatic logic [255:0] lanes(input logic [31:0] v, input logic [31:0] v3);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = (i == 3) ? v3 : v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int m, input int l, input logic [31:0] v, input logic [31:0] v3);
    exp_t e;
    e.mem  = m;
    e.line = l;
    e.data = lanes(v, v3);
    exp_q.push_back(e);
  endtask

  task automatic fill(input int m, input int l, input logic [31:0] v, input logic [31:0] v3);
    mem[m][l] = lanes(v, v3);
  endtask

  task automatic setup(input logic [31:0] sa, input logic [31:0] sb, input logic [31:0] dst,
                       input logic [31:0] cnt, input logic [31:0] mode);
    hregs[1] = sa;
    hregs[2] = sb;
    hregs[3] = dst;
    hregs[4] = cnt;
    hregs[6] = mode;
  endtask

  // Pulse lands in the cycle of the next negedge; returns mid-way through the following cycle.
  task automatic pulse_ctrl(input logic [31:0] ctrl);
    @(negedge clk);
    hregs[0]  = ctrl;
    hpulse[0] = 1'b1;
    @(negedge clk);
    hpulse[0] = 1'b0;
  endtask

  task automatic soc_wr(input logic [18:0] a);
    @(negedge clk);
    taddr = a;
    twr   = 1'b1;
    @(negedge clk);
    twr   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (status[0] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 256'(status[0]), 256'(0));
  endtask

  // Monitor: counts strobes and checks every write against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < NM; m++) begin
        if (rd[m]) strobes++;
        if (wr[m]) begin
          exp_t e;
          strobes++;
          $display("txn wr mem%0d line%0d data %h", m, addr[m], wdata[m]);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr: got write mem%0d line%0d required none", m, addr[m]);
          end else begin
            e = exp_q.pop_front();
            chk("wr_mem",  256'(m),        256'(e.mem));
            chk("wr_line", 256'(addr[m]),  256'(e.line));
            chk("wr_data", wdata[m],       e.data);
            chk("wr_be",   256'(be[m]),    256'(32'hFFFF_FFFF));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_lo [4];
  logic [31:0] exp_l3 [4];
  int          s0;

  initial begin
    checks  = 0;
    errors  = 0;
    strobes = 0;
    rst     = 1'b1;
    hregs   = '0;
    hpulse  = '0;
    taddr   = '0;
    twr     = 1'b0;
    rdata   = '0;
    for (int m = 0; m < NM; m++)
      for (int l = 0; l < 16; l++) mem[m][l] = '0;

    exp_lo = '{32'h0000_0010, 32'hFFFF_FFD0, 32'hFFFF_FFFF, 32'hFFFF_FFD0};
    exp_l3 = '{32'h0000_0008, 32'hFFFF_FFFE, 32'h0000_0008, 32'h0000_0000};

    repeat (3) @(negedge clk);
    chk("rst_status", 256'(status), 256'(0));
    chk("rst_valid",  256'(hvalid), 256'(32'h20));
    chk("rst_strobe", 256'({rd, wr}), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic add: 5 + 7 over four lines into mem0 lines 4..7.
    for (int l = 0; l < 4; l++) begin
      fill(0, l, 32'd5, 32'd5);
      fill(1, l, 32'd7, 32'd7);
      push(0, 4 + l, 32'd12, 32'd12);
    end
    setup(32'h000, 32'h100, 32'h004, 32'd4, 32'd0);
    pulse_ctrl(32'h1);
    chk("busy_t1",  256'(status[0]), 256'(1));
    chk("first_rd", 256'({rd, addr[0]}), 256'({2'b01, 4'h0}));
    repeat (15) @(negedge clk);
    chk("last_wr_t16", 256'({wr, status[0]}), 256'({2'b01, 1'b1}));
    @(negedge clk);
    chk("done_t17", 256'(status), 256'(32'h0004_0002));
    chk("mem0_line5", mem[0][5], lanes(32'd12, 32'd12));

    // All four modes on a saturating/wrapping lane pattern.
    for (int md = 0; md < 4; md++) begin
      fill(0, 8, 32'hFFFF_FFF0, 32'd3);
      fill(1, 8, 32'h0000_0020, 32'd5);
      setup(32'h008, 32'h108, 32'h00A, 32'd1, 32'(md));
      push(0, 10, exp_lo[md], exp_l3[md]);
      pulse_ctrl(32'h1);
      wait_idle(20);
      chk("mode_status", 256'(status), 256'(32'h0001_0002));
    end

    // Line pointers wrap 14, 15, 0, 1.
    fill(0, 14, 32'h100, 32'h100); fill(1, 14, 32'd1, 32'd1);
    fill(0, 15, 32'h200, 32'h200); fill(1, 15, 32'd2, 32'd2);
    fill(0, 0,  32'h300, 32'h300); fill(1, 0,  32'd3, 32'd3);
    fill(0, 1,  32'h400, 32'h400); fill(1, 1,  32'd4, 32'd4);
    push(1, 4, 32'h101, 32'h101);
    push(1, 5, 32'h202, 32'h202);
    push(1, 6, 32'h303, 32'h303);
    push(1, 7, 32'h404, 32'h404);
    setup(32'h00E, 32'h10E, 32'h104, 32'd4, 32'd0);
    pulse_ctrl(32'h1);
    wait_idle(40);
    chk("wrap_status", 256'(status), 256'(32'h0004_0002));

    // Armed trigger: mismatch ignored, match starts once, then disarmed.
    setup(32'h000, 32'h100, 32'h00C, 32'd1, 32'd0);
    hregs[7] = 32'h0000_0123;
    pulse_ctrl(32'h2);
    chk("arm_no_start", 256'(status[0]), 256'(0));
    soc_wr(19'h00122);
    chk("trig_miss", 256'(status[0]), 256'(0));
    push(0, 12, 32'h303, 32'h303);
    soc_wr(19'h00123);
    chk("trig_hit", 256'(status[0]), 256'(1));
    wait_idle(20);
    chk("trig_done", 256'(status), 256'(32'h0001_0002));
    soc_wr(19'h00123);
    chk("trig_oneshot", 256'(status[0]), 256'(0));

    // Bad memory index: immediate DONE+ERR, no memory traffic.
    setup(32'h000, 32'h300, 32'h00C, 32'd1, 32'd0);
    s0 = strobes;
    pulse_ctrl(32'h1);
    chk("err_start", 256'(status), 256'(32'h0000_0006));
    setup(32'h000, 32'h100, 32'h00C, 32'd0, 32'd0);
    pulse_ctrl(32'h1);
    chk("count0", 256'(status), 256'(32'h0000_0002));
    repeat (6) @(negedge clk);
    chk("err_no_strobes", 256'(strobes), 256'(s0));

    // Abort during the second of four lines.
    setup(32'h000, 32'h100, 32'h004, 32'd4, 32'd0);
    push(0, 4, 32'h303, 32'h303);
    pulse_ctrl(32'h1);
    repeat (4) @(negedge clk);
    pulse_ctrl(32'h4);
    chk("abort_status", 256'(status), 256'(32'h0001_0008));
    s0 = strobes;
    repeat (10) @(negedge clk);
    chk("abort_quiet", 256'(strobes), 256'(s0));

    // START while busy is ignored.
    setup(32'h000, 32'h100, 32'h006, 32'd2, 32'd0);
    push(0, 6, 32'h303, 32'h303);
    push(0, 7, 32'h404, 32'h404);
    pulse_ctrl(32'h1);
    pulse_ctrl(32'h1);
    repeat (5) @(negedge clk);
    chk("busy_t8", 256'(status[0]), 256'(1));
    @(negedge clk);
    chk("busy_ignore_done", 256'(status), 256'(32'h0002_0002));

    // Asynchronous reset during WR.
    setup(32'h000, 32'h100, 32'h00E, 32'd1, 32'd0);
    push(0, 14, 32'h303, 32'h303);
    pulse_ctrl(32'h1);
    repeat (3) @(negedge clk);
    chk("wr_before_rst", 256'(wr), 256'(2'b01));
    #2 rst = 1'b1;
    #1;
    chk("wr_drop",       256'({rd, wr}), 256'(0));
    chk("status_in_rst", 256'(status), 256'(0));
    chk("valid_in_rst",  256'(hvalid), 256'(32'h20));
    @(negedge clk);
    rst = 1'b0;
    s0  = strobes;
    repeat (8) @(negedge clk);
    chk("status_after_rst", 256'(status), 256'(0));
    chk("no_resume",        256'(strobes), 256'(s0));

    chk("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
